// File: rtl/bk_mp_add_ctrl_if.sv
// bk_mp_add_ctrl_if: request/result handshake bundle for the multi-precision add sequencer
interface bk_mp_add_ctrl_if #(parameter int WORDS = 4);
  localparam int W = 32 * WORDS;
  logic in_valid, in_ready;
  logic [W-1:0] a, b;
  logic cin, sub;
  logic out_valid, out_ready;
  logic [W-1:0] sum;
  logic cout, ovf;
  modport master (output in_valid, a, b, cin, sub, out_ready, input in_ready, out_valid, sum, cout, ovf);
  modport slave (input in_valid, a, b, cin, sub, out_ready, output in_ready, out_valid, sum, cout, ovf);
endinterface

// File: rtl/bk_mp_add_ctrl.sv
// bk_mp_add_ctrl: word-serial wide add/subtract over one shared 32-bit Brent-Kung adder
module bk_adder_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [31:0] p, g9;
  logic gg [0:9][0:31];
  logic pp [0:8][0:31];
  assign p = a ^ b;
  genvar l, i;
  generate
    for (i = 0; i < 32; i++) begin : g_init
      if (i == 0) begin : g_c
        assign gg[0][i] = (a[i] & b[i]) | (p[i] & cin);
      end else begin : g_n
        assign gg[0][i] = a[i] & b[i];
      end
      assign pp[0][i] = p[i];
      assign g9[i] = gg[9][i];
    end
    // levels 1..5 reduce up the tree, 6..9 fill in the remaining prefixes
    for (l = 1; l < 10; l++) begin : g_lvl
      for (i = 0; i < 32; i++) begin : g_bit
        localparam int d = (l <= 5) ? (1 << (l - 1)) : (1 << (9 - l));
        localparam bit hit = (l <= 5) ? ((i + 1) % (2 * d) == 0) : (((i + 1) % (2 * d) == d) && (i >= 3 * d - 1));
        if (hit) begin : g_op
          assign gg[l][i] = gg[l-1][i] | (pp[l-1][i] & gg[l-1][i-d]);
          if (l < 9) begin : g_p
            assign pp[l][i] = pp[l-1][i] & pp[l-1][i-d];
          end
        end else begin : g_pass
          assign gg[l][i] = gg[l-1][i];
          if (l < 9) begin : g_p
            assign pp[l][i] = pp[l-1][i];
          end
        end
      end
    end
  endgenerate
  assign sum = p ^ {g9[30:0], cin};
  assign cout = g9[31];
endmodule

module bk_mp_add_ctrl #(parameter int WORDS = 4) (
  input logic clk,
  input logic rst,
  bk_mp_add_ctrl_if.slave io
);
  localparam int W = 32 * WORDS;
  localparam logic [3:0] last_idx = 4'(WORDS - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [W-1:0] a_r, b_r;
  logic sub_r, c_r;
  logic [3:0] idx;
  logic [31:0] aw, bw, sw;
  logic co;
  always_comb begin
    aw = '0;
    bw = '0;
    for (int k = 0; k < WORDS; k++)
      if (idx == 4'(k)) begin
        aw = a_r[32*k +: 32];
        bw = b_r[32*k +: 32];
      end
    bw = sub_r ? ~bw : bw;
  end
  bk_adder_32 u_add (.a(aw), .b(bw), .cin(c_r), .sum(sw), .cout(co));
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = io.in_valid ? RUN : IDLE;
      RUN: state_nx = (idx == last_idx) ? DONE : RUN;
      DONE: state_nx = io.out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  assign io.in_ready = state == IDLE;
  assign io.out_valid = state == DONE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      sub_r <= 1'b0;
      c_r <= 1'b0;
      idx <= '0;
      io.sum <= '0;
      io.cout <= 1'b0;
      io.ovf <= 1'b0;
    end else if (state == IDLE && io.in_valid) begin
      a_r <= io.a;
      b_r <= io.b;
      sub_r <= io.sub;
      c_r <= io.sub | io.cin;
      idx <= '0;
    end else if (state == RUN) begin
      for (int k = 0; k < WORDS; k++)
        if (idx == 4'(k)) io.sum[32*k +: 32] <= sw;
      c_r <= co;
      idx <= idx + 4'd1;
      if (idx == last_idx) begin
        io.cout <= co;
        io.ovf <= (aw[31] == bw[31]) && (sw[31] != aw[31]);
      end
    end
endmodule
